// File: rtl/block_to_raster_if.sv
// Stream bundle for block_to_raster: block-order pixel input and
// raster-order pixel output, each with a valid/ready handshake.
interface block_to_raster_if #(
    parameter int DATA_W = 24
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;
    logic              out_sol;
    logic              out_eol;
    logic              out_eos;

    // Source/sink side (drives pixels in, accepts pixels out)
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_sol, out_eol, out_eos
    );

    // Reorder block side
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_sol, out_eol, out_eos
    );
endinterface

// File: rtl/block_to_raster.sv
// 8x8 block stream to raster-scan reorder buffer. Two 8-line banks
// ping-pong: one is filled in block order while the other is read out
// line by line into a 2-entry output skid buffer.
module block_to_raster #(
    parameter int WIDTH  = 1280,
    parameter int DATA_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    block_to_raster_if.slave bus
);
    localparam int BW    = $clog2(WIDTH / 8);
    localparam int XW    = BW + 3;
    localparam int AW    = BW + 6;
    localparam int DEPTH = 1 << AW;
    localparam logic [BW-1:0] BLK_LAST = BW'(WIDTH / 8 - 1);
    localparam logic [XW-1:0] X_LAST   = XW'(WIDTH - 1);

    typedef struct packed {
        logic              sol;
        logic              eol;
        logic              eos;
        logic [DATA_W-1:0] data;
    } beat_t;

    logic [DATA_W-1:0] bank0 [DEPTH];
    logic [DATA_W-1:0] bank1 [DEPTH];

    // write side
    logic [5:0]    k;
    logic [BW-1:0] blk;
    logic          wsel;
    logic [1:0]    full;
    logic          accept;
    logic          wr_last;
    logic [AW-1:0] wr_addr;

    // read side
    logic [2:0]    row;
    logic [XW-1:0] x;
    logic          rsel;
    logic          issue;
    logic          rd_last;
    logic [AW-1:0] rd_addr;
    logic [DATA_W-1:0] q0;
    logic [DATA_W-1:0] q1;
    logic          issue_q;
    logic          bank_q;
    logic [2:0]    mark_q;

    // skid buffer
    beat_t         fifo [2];
    beat_t         rd_beat;
    beat_t         head;
    logic          wptr;
    logic          rptr;
    logic [1:0]    count;
    logic          push;
    logic          pop;

    // Handshake qualification, addressing and read-issue decision
    always_comb begin
        accept  = bus.in_valid && !full[wsel];
        wr_last = accept && (k == 6'd63) && (blk == BLK_LAST);
        wr_addr = {k[5:3], blk, k[2:0]};
        pop     = (count != 2'd0) && bus.out_ready;
        push    = issue_q;
        // a read in the RAM pipe already owns a skid slot
        issue   = full[rsel] &&
                  (({1'b0, count} + {2'b00, issue_q}) < (3'd2 + {2'b00, pop}));
        rd_last = issue && (row == 3'd7) && (x == X_LAST);
        rd_addr = {row, x};
    end

    // Output ports from registered state
    always_comb begin
        head          = fifo[rptr];
        rd_beat       = {mark_q, (bank_q ? q1 : q0)};
        bus.in_ready  = !full[wsel];
        bus.out_valid = (count != 2'd0);
        bus.out_data  = head.data;
        bus.out_sol   = head.sol;
        bus.out_eol   = head.eol;
        bus.out_eos   = head.eos;
    end

    // Write counters and write bank select
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k    <= '0;
            blk  <= '0;
            wsel <= 1'b0;
        end else if (accept) begin
            k <= k + 6'd1;
            if (k == 6'd63) blk <= (blk == BLK_LAST) ? '0 : blk + BW'(1);
            if (wr_last) wsel <= ~wsel;
        end
    end

    // Bank full flags; set and clear always target different banks
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full <= '0;
        end else begin
            if (wr_last) full[wsel] <= 1'b1;
            if (rd_last) full[rsel] <= 1'b0;
        end
    end

    // Read counters and read bank select
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row  <= '0;
            x    <= '0;
            rsel <= 1'b0;
        end else if (issue) begin
            if (x == X_LAST) begin
                x   <= '0;
                row <= row + 3'd1;
            end else begin
                x <= x + XW'(1);
            end
            if (rd_last) rsel <= ~rsel;
        end
    end

    // Bank 0 RAM: write port plus registered read port
    always_ff @(posedge clk) begin
        if (accept && !wsel) bank0[wr_addr] <= bus.in_data;
        if (issue && !rsel) q0 <= bank0[rd_addr];
    end

    // Bank 1 RAM: write port plus registered read port
    always_ff @(posedge clk) begin
        if (accept && wsel) bank1[wr_addr] <= bus.in_data;
        if (issue && rsel) q1 <= bank1[rd_addr];
    end

    // Markers and bank tag travel alongside the RAM read latency
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_q <= 1'b0;
            bank_q  <= 1'b0;
            mark_q  <= '0;
        end else begin
            issue_q <= issue;
            if (issue) begin
                bank_q <= rsel;
                mark_q <= {(x == '0), (x == X_LAST), ((row == 3'd7) && (x == X_LAST))};
            end
        end
    end

    // Two-entry output skid buffer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo[0] <= '0;
            fifo[1] <= '0;
            wptr    <= 1'b0;
            rptr    <= 1'b0;
            count   <= '0;
        end else begin
            if (push) begin
                fifo[wptr] <= rd_beat;
                wptr       <= ~wptr;
            end
            if (pop) rptr <= ~rptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end
endmodule

// File: tb/tb_block_to_raster.sv
// Randomized self-checking bench for block_to_raster (WIDTH = 16).
// Reference: each complete strip of accepted pixels is transposed into
// raster order with plain index arithmetic and queued as expected output.
module tb_block_to_raster;
    localparam int WIDTH  = 16;
    localparam int DATA_W = 24;
    localparam int STRIP  = 8 * WIDTH;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic [2:0]        mk;   // sol, eol, eos
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    block_to_raster_if #(.DATA_W(DATA_W)) bus ();

    block_to_raster #(.WIDTH(WIDTH), .DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int unsigned n_checks = 0;
    int unsigned n_bad    = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // reference model state
    logic [DATA_W-1:0] strip_buf [STRIP];
    exp_t exp_q [$];
    exp_t e;
    int   fill = 0;
    int   acc_total = 0;
    int   pop_total = 0;
    int   cyc = 0;
    int   last_acc = -1;
    int   first_valid = -1;
    int   first_pop = -1;
    int   last_pop = -1;
    int   stall_cnt = 0;
    bit   chk_full = 0;

    // stimulus controls
    int   phase = 0;
    int   in_target = 0;
    bit   in_rand = 0;
    bit   pattern = 0;
    int   out_mode = 0;

    always @(posedge clk) cyc++;

    // Observe handshakes between edges; they complete at the next edge
    always @(negedge clk) begin
        if (!rst) begin
            if (chk_full) begin
                check("full_after_collision", 32'(dut.full), 32'h2);
                chk_full = 0;
            end
            if (bus.out_valid && first_valid < 0) first_valid = cyc;
            if (phase == 2 && acc_total >= STRIP && acc_total < in_target && !bus.in_ready)
                stall_cnt++;
            if (bus.in_valid && bus.in_ready) begin
                strip_buf[fill] = bus.in_data;
                fill++;
                acc_total++;
                last_acc = cyc + 1;
                if (phase == 2 && acc_total == 2 * STRIP) chk_full = 1;
                if (fill == STRIP) begin
                    for (int r = 0; r < 8; r++) begin
                        for (int xx = 0; xx < WIDTH; xx++) begin
                            e.data = strip_buf[(xx / 8) * 64 + r * 8 + (xx % 8)];
                            e.mk   = {xx == 0, xx == WIDTH - 1, (r == 7) && (xx == WIDTH - 1)};
                            exp_q.push_back(e);
                        end
                    end
                    fill = 0;
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 32'(bus.out_data), 32'hdead);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", 32'(bus.out_data), 32'(e.data));
                    check("out_markers", {29'd0, bus.out_sol, bus.out_eol, bus.out_eos}, 32'(e.mk));
                end
                pop_total++;
                if (first_pop < 0) first_pop = cyc + 1;
                last_pop = cyc + 1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (acc_total < in_target) begin
            bus.in_valid = in_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.in_data  = pattern ? DATA_W'(acc_total % STRIP) : DATA_W'($urandom);
        end else begin
            bus.in_valid = 1'b0;
        end
        case (out_mode)
            0:       bus.out_ready = 1'b0;
            1:       bus.out_ready = 1'b1;
            default: bus.out_ready = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic do_reset();
        bus.in_valid = 1'b0;
        in_target = 0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_data", 32'(bus.out_data), 32'd0);
        check("rst_markers", {29'd0, bus.out_sol, bus.out_eol, bus.out_eos}, 32'd0);
        fill = 0;
        exp_q.delete();
        acc_total = 0;
        pop_total = 0;
        last_acc = -1;
        first_valid = -1;
        first_pop = -1;
        last_pop = -1;
        stall_cnt = 0;
        chk_full = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic run_until_done(input int max_cycles);
        int n = 0;
        while (!(acc_total >= in_target && exp_q.size() == 0 && !bus.out_valid && fill == 0)
               && n < max_cycles) begin
            step();
            n++;
        end
        check("drain_in_time", 32'(n < max_cycles), 32'd1);
    endtask

    task automatic run_until_accepted(input int count, input int max_cycles);
        int n = 0;
        while (acc_total < count && n < max_cycles) begin
            step();
            n++;
        end
        check("accept_in_time", 32'(acc_total >= count), 32'd1);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);

        // 1: single strip, known pattern, sink always ready
        do_reset();
        phase = 1; pattern = 1; in_rand = 0; out_mode = 1; in_target = STRIP;
        run_until_done(1000);
        check("t1_latency", 32'(first_valid - last_acc), 32'd2);
        check("t1_count", 32'(pop_total), 32'(STRIP));

        // 2: four back-to-back strips at full rate, includes set/clear collision
        do_reset();
        phase = 2; pattern = 1; in_rand = 0; out_mode = 1; in_target = 4 * STRIP;
        run_until_done(2000);
        check("t2_count", 32'(pop_total), 32'(4 * STRIP));
        check("t2_no_gaps", 32'(last_pop - first_pop), 32'(4 * STRIP - 1));
        check("t2_no_stall", 32'(stall_cnt), 32'd0);

        // 3: sink stalled while three strips are offered
        do_reset();
        phase = 3; pattern = 0; in_rand = 0; out_mode = 0; in_target = 3 * STRIP;
        repeat (600) step();
        check("t3_accepted", 32'(acc_total), 32'(2 * STRIP));
        check("t3_in_ready", 32'(bus.in_ready), 32'd0);
        check("t3_out_valid", 32'(bus.out_valid), 32'd1);
        check("t3_head_held", 32'(bus.out_data), 32'(exp_q[0].data));
        out_mode = 1;
        run_until_done(3000);
        check("t3_count", 32'(pop_total), 32'(3 * STRIP));

        // 4: random valid and ready over six strips
        do_reset();
        phase = 4; pattern = 0; in_rand = 1; out_mode = 2; in_target = 6 * STRIP;
        run_until_done(20000);
        check("t4_count", 32'(pop_total), 32'(6 * STRIP));

        // 5a: reset mid-strip with nothing being read
        do_reset();
        phase = 5; pattern = 0; in_rand = 0; out_mode = 1; in_target = 70;
        run_until_accepted(70, 500);
        do_reset();
        in_target = STRIP;
        run_until_done(1000);
        check("t5a_count", 32'(pop_total), 32'(STRIP));

        // 5b: reset mid-strip while the other bank is being read out
        do_reset();
        in_target = STRIP + 70;
        run_until_accepted(STRIP + 70, 1000);
        check("t5b_reading", 32'(bus.out_valid), 32'd1);
        do_reset();
        in_target = STRIP;
        run_until_done(1000);
        check("t5b_count", 32'(pop_total), 32'(STRIP));

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end
endmodule

// File: doc/block_to_raster.md
# block_to_raster

Reorders a stream of 8x8 pixel blocks back into raster-scan order. It is the inverse of the raster-to-block ping-pong buffer in front of the DCT, and sits after the IDCT / reconstruction path, feeding display or DVP-style output logic. Two 8-line banks alternate: one is written in block order while the other is read out line by line. Both sides use a valid/ready handshake, and everything runs on a single clock.

## Interface
- `WIDTH`, default 1280: pixels per line. Must be a multiple of 8, and ≥ 16.
- `DATA_W`, default 24: pixel width in bits (RGB888 packed).
- `clk`, input, 1: the only clock.
- `rst`, input, 1: reset, asynchronous and active-high.
- `in_valid`, input, 1: `in_data` is valid.
- `in_data`, input, `DATA_W`: pixel in block order.
- `in_ready`, output, 1: the block accepts input this cycle.
- `out_valid`, output, 1: `out_data` is valid.
- `out_data`, output, `DATA_W`: pixel in raster order.
- `out_ready`, input, 1: the sink accepts output this cycle.
- `out_sol`, output, 1: first pixel of a line (x = 0). Qualified by `out_valid`.
- `out_eol`, output, 1: last pixel of a line (x = `WIDTH`-1). Qualified by `out_valid`.
- `out_eos`, output, 1: last pixel of a strip (row 7, x = `WIDTH`-1). Qualified by `out_valid`.

## Operation
**Definitions**
- A strip is 8 lines, which is `WIDTH`/8 blocks.
- `BW` = $clog2(`WIDTH`/8).
- Bank address is {row[2:0], blk[BW-1:0], col[2:0]}.
- Bank depth is 2^(`BW`+6).
- Each bank is a simple dual-port RAM with a registered read and 1-cycle latency.

**Input order and write side**
- Input order within a block is row-major: pixel k = 0..63 has row = k[5:3] and col = k[2:0].
- Blocks arrive left to right: blk = 0..`WIDTH`/8-1.
- Write counters: k (6 bit) and blk (`BW` bit). They advance only on an accepted input (`in_valid` & `in_ready`).
- k wraps 63→0 and increments blk. blk wraps at `WIDTH`/8-1 → 0.
- Write bank select `wsel` starts at bank 0.
- `in_ready` = !full[`wsel`]. It is combinational, from registered flags.
- On acceptance of k = 63 with blk = `WIDTH`/8-1: set full[`wsel`] and toggle `wsel` at the same edge.

**Read side**
- Counters: row (3 bit) and x (`BW`+3 bit). Read address is {row, x}, which equals {row, x[`BW`+2:3], x[2:0]}.
- Read bank select `rsel` starts at bank 0.
- A read is issued when full[`rsel`] is set and the output skid buffer will have a free slot. The slot condition is: occupancy + in-flight reads − the pop this cycle < 2.
- Each issued read advances x. x wraps at `WIDTH`-1 → 0 and increments row.
- When the read with row = 7 and x = `WIDTH`-1 is issued: clear full[`rsel`] and toggle `rsel` at the same edge.
- sol, eol and eos are computed at issue time and travel with the data.

**Output skid buffer**
- 2-entry FIFO holding data plus the three markers.
- `out_valid` = not empty.
- Pop on `out_valid` & `out_ready`.
- `out_data` and the markers come from the head register.

**Flags and corner cases**
- full[0] and full[1] are independent. Setting one bank while clearing the other in the same cycle is legal, and both actions take effect.
- Set and clear never target the same bank in the same cycle: writes only occur when a bank is not full, reads only when it is full.
- Both banks full: `in_ready` = 0 until the read side releases the bank at its last issued read.
- Both banks empty: `out_valid` drops once the skid buffer drains.

**Reset** (`rst` = 1), all asynchronous:
- Counters cleared, `wsel` = `rsel` = 0, full flags cleared, skid buffer emptied.
- Outputs: `out_valid` = 0, `out_data` = 0, `out_sol` = `out_eol` = `out_eos` = 0, `in_ready` = 1.
- Reset mid-strip discards all buffered pixels. The next accepted input is k = 0, blk = 0.
- RAM contents are not reset.

## Timing
- Write: data is stored on the edge where the handshake occurs.
- The full flag is visible the cycle after the last strip pixel is accepted.
- Latency: the last input of a strip is accepted at edge T. The first read is issued in cycle T+1. `out_valid` = 1 from T+2, provided the skid buffer was empty.
- Throughput with `out_ready` held at 1: 1 pixel per clock, with no bubbles between lines or between strips, as long as the next bank is full.
- `out_ready` low: at most 2 reads are outstanding plus buffered, so no data is lost. Reads resume in the cycle after a pop frees a slot.
- Steady state: output of a strip takes 8·`WIDTH` cycles and input takes 8·`WIDTH` accepted beats. With both sides at full rate, `in_ready` never deasserts.

## Test plan
All scenarios use `WIDTH` = 16, i.e. 2 blocks and 128 pixels per strip.

1. Single strip. Input pixel value = blk·64 + k, streamed without gaps; `out_ready` = 1.
   - Output line r, position x = (x/8)·64 + r·8 + (x%8).
   - First `out_valid` is 2 cycles after the last input.
   - `out_sol` at x = 0, `out_eol` at x = 15, `out_eos` only on output #127.
2. Continuous 4 strips at full rate on both sides.
   - `in_ready` stays 1 after the first strip.
   - 512 outputs in order with no gap after the first.
   - Banks alternate 0, 1, 0, 1.
3. Hold `out_ready` = 0 while feeding 3 strips.
   - `in_ready` falls after pixel 256; the third strip is stalled.
   - `out_valid` = 1 holds the first pixel unchanged.
   - Releasing `out_ready` drains in correct order and the third strip then completes.
4. Random `out_ready` (50%) and random `in_valid` over 6 strips.
   - Scoreboard matches exactly.
   - Skid buffer never overflows, and no duplicate or missing pixel appears.
5. Assert `rst` for 1 cycle mid-strip (after 70 inputs), both while idle and while reading.
   - `out_valid` goes to 0 immediately and `in_ready` = 1.
   - The next 128 inputs produce one correct strip.
6. Set/clear collision: arrange for the last write of a strip into bank 1 to land in the same cycle as the last read issue of bank 0.
   - Both flags update correctly: full = {1, 0}.
   - Output continues from bank 1 without a bubble.
